// File: rtl/vga_timing_gen_if.sv
// Pixel stream between the frame-buffer reader (master) and the timing
// generator (slave). A pixel moves on any clk edge where valid and ready
// are both high; data is packed {r,g,b}, CW bits per channel.
interface vga_timing_gen_if #(
    parameter int CW = 8
);
    logic            valid;
    logic            ready;
    logic [3*CW-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. A horizontal/vertical counter
// pair walks the raster one position per pix_en tick. Every output is
// registered from the counter position of the same tick, so the pins lag the
// counters by exactly one tick. Pixels are pulled from a valid/ready stream
// only at active positions. A missing pixel shows UF_COLOR and sets a sticky
// underflow flag. Dropping en lets the current frame finish before the
// generator parks in IDLE with the syncs inactive.
module vga_timing_gen #(
    parameter int            CW       = 8,
    parameter int            CNT_W    = 10,
    parameter int            H_SYNC   = 96,
    parameter int            H_BP     = 48,
    parameter int            H_ACT    = 640,
    parameter int            H_FP     = 16,
    parameter int            V_SYNC   = 2,
    parameter int            V_BP     = 33,
    parameter int            V_ACT    = 480,
    parameter int            V_FP     = 10,
    parameter bit            HS_POL   = 1'b0,
    parameter bit            VS_POL   = 1'b0,
    parameter logic [3*CW-1:0] UF_COLOR = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en_i,
    input  logic             pix_en_i,
    vga_timing_gen_if.slave  pix,
    output logic [CW-1:0]    vga_r_o,
    output logic [CW-1:0]    vga_g_o,
    output logic [CW-1:0]    vga_b_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             de_o,
    output logic [CNT_W-1:0] x_addr_o,
    output logic [CNT_W-1:0] y_addr_o,
    output logic             frame_start_o,
    output logic             line_start_o,
    output logic             underflow_o,
    input  logic             underflow_clr_i,
    output logic             busy_o
);

    localparam int PW      = 3 * CW;
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

    // Region boundaries as counter-width constants. The active window uses an
    // inclusive last index so a zero front porch cannot overflow CNT_W.
    localparam logic [CNT_W-1:0] H_SYNC_END  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_FIRST = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_ACT_LAST  = CNT_W'(H_SYNC + H_BP + H_ACT - 1);
    localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_SYNC_END  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] V_ACT_FIRST = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_ACT_LAST  = CNT_W'(V_SYNC + V_BP + V_ACT - 1);
    localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  hc_q;
    logic [CNT_W-1:0]  vc_q;
    logic [CNT_W-1:0]  hc_d;
    logic [CNT_W-1:0]  vc_d;

    logic              h_last;
    logic              v_last;
    logic              h_sync;
    logic              v_sync;
    logic              h_act;
    logic              v_act;
    logic              act;
    logic              pix_ready;
    logic              uf_set;

    logic [PW-1:0]     rgb_q;
    logic              hsync_q;
    logic              vsync_q;
    logic              de_q;
    logic [CNT_W-1:0]  x_q;
    logic [CNT_W-1:0]  y_q;
    logic              frame_start_q;
    logic              line_start_q;
    logic              underflow_q;

    // Raster decode of the current position and the wrapped next position.
    always_comb begin
        h_last = (hc_q == H_LAST);
        v_last = (vc_q == V_LAST);
        hc_d   = h_last ? '0 : hc_q + 1'b1;
        vc_d   = vc_q;
        if (h_last) begin
            vc_d = v_last ? '0 : vc_q + 1'b1;
        end
        h_sync    = (hc_q < H_SYNC_END);
        v_sync    = (vc_q < V_SYNC_END);
        h_act     = (hc_q >= H_ACT_FIRST) && (hc_q <= H_ACT_LAST);
        v_act     = (vc_q >= V_ACT_FIRST) && (vc_q <= V_ACT_LAST);
        act       = h_act && v_act;
        pix_ready = pix_en_i && act && (state_q != S_IDLE);
        uf_set    = pix_ready && !pix.valid;
    end

    // Run-control FSM and raster counters; everything moves only on pix_en ticks.
    // Leaving IDLE parks the counters at (0,0) so the first RUN tick shows the
    // frame origin. STOP keeps scanning and drops to IDLE only after the
    // final position of the frame, where the wrap already yields (0,0).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            hc_q    <= '0;
            vc_q    <= '0;
        end else if (pix_en_i) begin
            case (state_q)
                S_IDLE: begin
                    hc_q <= '0;
                    vc_q <= '0;
                    if (en_i) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    hc_q <= hc_d;
                    vc_q <= vc_d;
                    if (!en_i) begin
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    hc_q <= hc_d;
                    vc_q <= vc_d;
                    if (en_i) begin
                        state_q <= S_RUN;
                    end else if (h_last && v_last) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    hc_q    <= '0;
                    vc_q    <= '0;
                end
            endcase
        end
    end

    // Output stage: capture the decode of this tick's position; pulses self-clear after one clk.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rgb_q         <= '0;
            hsync_q       <= !HS_POL;
            vsync_q       <= !VS_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
            if (pix_en_i) begin
                if (state_q == S_IDLE) begin
                    rgb_q   <= '0;
                    hsync_q <= !HS_POL;
                    vsync_q <= !VS_POL;
                    de_q    <= 1'b0;
                    x_q     <= '0;
                    y_q     <= '0;
                end else begin
                    hsync_q       <= h_sync ? HS_POL : !HS_POL;
                    vsync_q       <= v_sync ? VS_POL : !VS_POL;
                    de_q          <= act;
                    rgb_q         <= !act ? '0 : (pix.valid ? pix.data : UF_COLOR);
                    x_q           <= act ? hc_q - H_ACT_FIRST : '0;
                    y_q           <= act ? vc_q - V_ACT_FIRST : '0;
                    frame_start_q <= act && (hc_q == H_ACT_FIRST) && (vc_q == V_ACT_FIRST);
                    line_start_q  <= act && (hc_q == H_ACT_FIRST);
                end
            end
        end
    end

    // Sticky underflow: a new underflow outranks a simultaneous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= uf_set || (underflow_q && !underflow_clr_i);
        end
    end

    assign pix.ready     = pix_ready;
    assign vga_r_o       = rgb_q[3*CW-1:2*CW];
    assign vga_g_o       = rgb_q[2*CW-1:CW];
    assign vga_b_o       = rgb_q[CW-1:0];
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
    assign x_addr_o      = x_q;
    assign y_addr_o      = y_q;
    assign frame_start_o = frame_start_q;
    assign line_start_o  = line_start_q;
    assign underflow_o   = underflow_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule
